uart_tx_buffered: RTL
=====================

Name: uart_tx_buffered

Overview:
Buffered UART transmitter for the host-to-line direction. Upstream logic pushes bytes through a valid/ready write port into an internal FIFO. A framing engine drains the FIFO and serialises each byte as start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits on the tx line. It sits between command/response logic and the board TX pin and is the counterpart to the existing receive-to-FIFO path.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2)
DEPTH, 16, FIFO depth in bytes, power of 2, >= 2
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
wr_valid  input  1  write request
wr_data  input  8  byte to transmit
wr_ready  output  1  FIFO can accept; equals !full
tx_enable  input  1  when low, no new frame starts; a frame in progress completes
tx  output  1  serial line, idle high, registered
busy  output  1  high while a frame is on the line
level  output  $clog2(DEPTH)+1  bytes currently in FIFO
overflow  output  1  one-cycle pulse when wr_valid=1 and wr_ready=0

Behaviour:
- Reset (async, immediate): tx=1, busy=0, level=0, overflow=0, FIFO pointers 0, FSM IDLE. Reset mid-frame aborts the frame, tx goes high at once, and FIFO contents are discarded.
- Write: the byte is accepted on an edge with wr_valid && wr_ready, and level increments after that edge. A write while full is dropped (no state change) and overflow=1 for the following cycle.
- Pop-while-full does not open a slot in the same cycle. wr_ready is !full, evaluated before the pop.
- Simultaneous accepted push and pop: level unchanged. Pointers wrap modulo DEPTH.
- FIFO head is read combinationally (mem[rd_ptr]), and the pop happens on the same edge the shift register loads.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START: on an edge where FIFO is non-empty && tx_enable. On that edge: pop, load the shift register, clear the bit timer, tx<=0.
- Timing: tx falls one edge after the write-accept edge when the FIFO was empty and the FSM was idle.
- Each bit is held exactly CLKS_PER_BIT cycles. The bit timer counts 0..CLKS_PER_BIT-1; at terminal count it advances to the next bit.
- START -> DATA. DATA sends bits 0..7 LSB-first using a 3-bit index.
- DATA -> PARITY if PARITY != 0, else STOP. Parity bit: odd = ~^byte, even = ^byte.
- STOP holds tx=1 for STOP_BITS bit periods.
- At the terminal count of the last stop bit:
  - if FIFO non-empty && tx_enable: pop, load, tx<=0, go to START (no idle gap between frames);
  - else go to IDLE.
- Frame length = (10 + (PARITY!=0) + (STOP_BITS-1)) * CLKS_PER_BIT cycles.
- busy = (state != IDLE), registered with the state.
- Deasserting tx_enable mid-frame has no effect on the current frame. Reasserting it resumes from IDLE.
- The write port stays fully functional during transmission.

Decomposition:
- Package uart_pkg:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - tx FSM state enum;
  - function clks_per_bit(freq, baud).
- Sub-module tx_byte_fifo:
  - synchronous FIFO with first-word-fall-through head, level output and full/empty flags;
  - parameterised WIDTH/DEPTH;
  - reusable by the receive path.
- Framing FSM and bit timer live in uart_tx_buffered.

Test Plan:
All scenarios use CLK_FREQ=1000000 and BAUD=100000, giving CLKS_PER_BIT=10.
- Single byte, PARITY=0, STOP_BITS=1: write 0xA5 into idle block -> tx low one edge later, then 10-cycle bits 0,1,0,1,0,0,1,0,1,1; busy high for exactly 100 cycles; level returns to 0.
- Parity: PARITY=2, write 0x03 -> parity bit 0, frame 110 cycles. PARITY=1, write 0x03 -> parity bit 1. PARITY=1, write 0x07 -> parity bit 0.
- Back-to-back: write 0x11, 0x22, 0x33 on consecutive cycles -> busy continuously high for 300 cycles; tx goes stop(1) directly into the next start(0), with no extra idle cycle; decoded bytes arrive in order.
- Full/overflow with tx_enable=0: 17 consecutive writes -> first 16 accepted, level=16, wr_ready=0, overflow pulses once for the 17th, tx stays 1. Raising tx_enable then yields 16 frames in write order.
- STOP_BITS=2, tx_enable dropped at cycle 30 of the first of two queued frames -> first frame completes in 110 cycles with a 20-cycle stop; second frame does not start; level=1.
- Reset at cycle 45 of a frame -> tx=1, busy=0, level=0 immediately. After release, an idle line with no spurious start bit.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the UART transmit/receive slice.
//   - PAR_NONE / PAR_ODD / PAR_EVEN : encodings of the PARITY parameter
//   - tx_state_t                    : framing FSM states
//   - clks_per_bit()                : system clocks per serial bit
//   - parity_bit()                  : parity bit for a data byte
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Integer division; the caller guarantees the result is at least 2.
   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

   // Odd parity makes the total count of ones (data + parity) odd,
   // even parity makes it even.
   function automatic logic parity_bit(input logic [7:0] data, input int mode);
      return (mode == PAR_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Write port of the buffered UART transmitter.
//   wr_valid : write request from upstream
//   wr_data  : byte to transmit
//   wr_ready : transmitter FIFO can accept (not full)
//   overflow : one-cycle pulse after a write that hit a full FIFO
// master = upstream producer, slave = transmitter.
interface uart_tx_buffered_if;

   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       overflow;

   modport master (
      output wr_valid,
      output wr_data,
      input  wr_ready,
      input  overflow
   );

   modport slave (
      input  wr_valid,
      input  wr_data,
      output wr_ready,
      output overflow
   );

endinterface

// File: rtl/uart_tx_buffered_tx_byte_fifo.sv
// Synchronous FIFO with a first-word-fall-through head.
//   clk, reset : clock, asynchronous active-high reset (clears pointers)
//   push       : write request; ignored while full
//   push_data  : data written on an accepted push
//   pop        : consume the head entry; ignored while empty
//   head       : current head entry, valid whenever empty is low
//   level      : number of stored entries (0..DEPTH)
//   full/empty : occupancy flags, both derived from level
// A pop on a full FIFO does not free a slot for a push in the same cycle:
// full is evaluated on the state before the edge. Used by the transmit path
// and sized generically so the receive path can reuse it.
module tx_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   // DEPTH is a power of two, so the full count is a single set MSB.
   localparam logic [AW:0] DEPTH_COUNT = {1'b1, {AW{1'b0}}};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == DEPTH_COUNT);
   assign empty   = (count == '0);
   assign level   = count;
   assign head    = mem[rd_ptr];

   // NOTE: the storage array has no reset; a slot is only read after it has
   // been written, so clearing it would just cost a reset tree on every bit.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointer width equals log2(DEPTH), so increments wrap naturally.
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a byte FIFO fed by a valid/ready write port,
// drained by a framing engine that sends start, 8 data bits LSB-first,
// optional parity and 1 or 2 stop bits.
//   clk, reset : clock, asynchronous active-high reset (aborts any frame)
//   wr         : write port (wr_valid, wr_data, wr_ready, overflow)
//   tx_enable  : gates the start of new frames; a running frame completes
//   tx         : registered serial output, idle high
//   busy       : high while a frame is on the line
//   level      : bytes waiting in the FIFO
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 115200,
   parameter int DEPTH     = 16,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   uart_tx_buffered_if.slave        wr,
   input  logic                     tx_enable,
   output logic                     tx,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int            CPB        = clks_per_bit(CLK_FREQ, BAUD);
   localparam int            TW         = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [TW-1:0] BIT_LAST   = TW'(CPB - 1);
   localparam logic          HAS_PARITY = (PARITY != PAR_NONE);
   localparam logic          TWO_STOP   = (STOP_BITS == 2);

   tx_state_t     state;
   logic [TW-1:0] bit_timer;
   logic [7:0]    shreg;
   logic [2:0]    bit_idx;
   logic          stop_idx;
   logic          par_bit;
   logic          overflow_q;

   logic [7:0]    fifo_head;
   logic          fifo_full;
   logic          fifo_empty;

   logic          bit_done;
   logic          last_stop;
   logic          start_frame;

   tx_byte_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr.wr_valid),
      .push_data (wr.wr_data),
      .pop       (start_frame),
      .head      (fifo_head),
      .level     (level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign wr.wr_ready = !fifo_full;
   assign wr.overflow = overflow_q;

   // A frame starts either from idle or straight out of the terminal count
   // of the last stop bit, which gives back-to-back frames with no gap.
   // The same signal pops the FIFO so the head is consumed on the load edge.
   always_comb begin
      // NOTE: every output of this block is assigned a default first, so no
      // path through it can leave a value held and infer a latch.
      bit_done    = (bit_timer == BIT_LAST);
      last_stop   = !TWO_STOP || stop_idx;
      start_frame = 1'b0;
      if (!fifo_empty && tx_enable) begin
         if (state == ST_IDLE) begin
            start_frame = 1'b1;
         end else if (state == ST_STOP && bit_done && last_stop) begin
            start_frame = 1'b1;
         end
      end
   end

   // Write rejected because the FIFO was full: flag it for one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= wr.wr_valid && fifo_full;
      end
   end

   // Framing FSM. tx and busy are registered alongside the state so the line
   // changes exactly on bit boundaries and busy tracks state != IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         tx        <= 1'b1;
         busy      <= 1'b0;
         bit_timer <= '0;
         shreg     <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         par_bit   <= 1'b0;
      end else if (start_frame) begin
         state     <= ST_START;
         tx        <= 1'b0;
         busy      <= 1'b1;
         bit_timer <= '0;
         shreg     <= fifo_head;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         // Latched at load so the parity bit does not depend on the shifted
         // contents of shreg later in the frame.
         par_bit   <= parity_bit(fifo_head, PARITY);
      end else begin
         if (state != ST_IDLE) begin
            bit_timer <= bit_done ? '0 : bit_timer + 1'b1;
         end
         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
            end
            ST_START: begin
               if (bit_done) begin
                  state <= ST_DATA;
                  tx    <= shreg[0];
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  if (bit_idx == 3'd7) begin
                     if (HAS_PARITY) begin
                        state <= ST_PARITY;
                        tx    <= par_bit;
                     end else begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     // shreg[0] is on the line; shreg[1] is the next bit.
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  state <= ST_STOP;
                  tx    <= 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  if (last_stop) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
